// File: rtl/aes_block_tx_ctrl_if.sv
// Byte-stream valid/ready link from the AES block transmit controller to the UART transmitter.
interface aes_block_tx_ctrl_if;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_data, output byte_valid, input byte_ready);
   modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/aes_block_tx_ctrl.sv
// Debounced push-button transmit controller: latches a plaintext or ciphertext block
// and streams it byte by byte to the UART over a valid/ready handshake.
module aes_block_tx_ctrl #(
   parameter int unsigned NUM_BYTES       = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 15000000,
   parameter bit          MSB_FIRST       = 1'b1
) (
   input  logic                             clock,
   input  logic                             rst,
   input  logic                             button,
   input  logic                             switch,
   input  logic [8*NUM_BYTES-1:0]           plain_data,
   input  logic [8*NUM_BYTES-1:0]           cipher_data,
   input  logic                             cipher_valid,
   aes_block_tx_ctrl_if.master              tx,
   output logic                             busy,
   output logic                             done,
   output logic [$clog2(NUM_BYTES+1)-1:0]   bytes_sent
);

   localparam int unsigned DATA_W = 8 * NUM_BYTES;
   localparam int unsigned SENT_W = $clog2(NUM_BYTES + 1);
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SRC = 2'd1,
      SEND     = 2'd2,
      FIN      = 2'd3
   } state_t;

   // Byte presented first from a block, honouring the configured byte order.
   function automatic logic [7:0] head_byte(input logic [DATA_W-1:0] v);
      if (MSB_FIRST) return v[DATA_W-1 -: 8];
      else           return v[7:0];
   endfunction

   // Block with its head byte removed, so the next head_byte is the following byte.
   function automatic logic [DATA_W-1:0] drop_byte(input logic [DATA_W-1:0] v);
      if (MSB_FIRST) return v << 8;
      else           return v >> 8;
   endfunction

   // ---------------- debouncer ----------------
   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] deb_cnt_q;
   logic             armed_q;
   logic             trigger_c;

   assign trigger_c = armed_q && (deb_cnt_q == CNT_W'(DEBOUNCE_CYCLES));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_cnt_q <= '0;
         armed_q   <= 1'b1;
      end else begin
         sync1_q <= button;
         sync2_q <= sync1_q;
         if (!sync2_q) begin
            deb_cnt_q <= '0;
            armed_q   <= 1'b1;
         end else begin
            if (deb_cnt_q != CNT_W'(DEBOUNCE_CYCLES)) deb_cnt_q <= deb_cnt_q + CNT_W'(1);
            // one trigger per press: re-armed only once the level goes low again
            if (trigger_c) armed_q <= 1'b0;
         end
      end
   end

   // ---------------- transfer FSM ----------------
   state_t              state_q, state_nx;
   logic [DATA_W-1:0]   sreg_q, sreg_nx;
   logic [7:0]          data_q, data_nx;
   logic                valid_q, valid_nx;
   logic [SENT_W-1:0]   sent_q, sent_nx;
   logic                done_nx;
   logic                busy_nx;
   logic                load_c;
   logic [DATA_W-1:0]   load_src_c;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sreg_q     <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sent_q     <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_nx;
         sreg_q     <= sreg_nx;
         data_q     <= data_nx;
         valid_q    <= valid_nx;
         sent_q     <= sent_nx;
         done       <= done_nx;
         busy       <= busy_nx;
      end
   end

   always_comb begin
      state_nx   = state_q;
      sreg_nx    = sreg_q;
      data_nx    = data_q;
      valid_nx   = valid_q;
      sent_nx    = sent_q;
      done_nx    = 1'b0;
      load_c     = 1'b0;
      load_src_c = plain_data;

      case (state_q)
         IDLE: begin
            if (trigger_c) begin
               sent_nx = '0;
               if (!switch) begin
                  load_c     = 1'b1;
                  load_src_c = plain_data;
               end else if (cipher_valid) begin
                  load_c     = 1'b1;
                  load_src_c = cipher_data;
               end else begin
                  state_nx = WAIT_SRC;
               end
            end
         end
         WAIT_SRC: begin
            if (cipher_valid) begin
               load_c     = 1'b1;
               load_src_c = cipher_data;
            end
         end
         SEND: begin
            if (tx.byte_ready) begin
               sent_nx = sent_q + SENT_W'(1);
               if (sent_q == SENT_W'(NUM_BYTES - 1)) begin
                  state_nx = FIN;
                  valid_nx = 1'b0;
                  done_nx  = 1'b1;
               end else begin
                  data_nx = head_byte(sreg_q);
                  sreg_nx = drop_byte(sreg_q);
               end
            end
         end
         FIN: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
         end
      endcase

      // first byte goes straight to the output register; sreg keeps the remainder
      if (load_c) begin
         state_nx = SEND;
         valid_nx = 1'b1;
         data_nx  = head_byte(load_src_c);
         sreg_nx  = drop_byte(load_src_c);
      end

      busy_nx = (state_nx != IDLE);
   end

   assign tx.byte_data  = data_q;
   assign tx.byte_valid = valid_q;
   assign bytes_sent    = sent_q;

endmodule

// File: tb/tb_aes_block_tx_ctrl.sv
// Randomised scoreboard bench for aes_block_tx_ctrl: an MSB-first and an LSB-first
// instance share the stimulus; a monitor pops expected bytes as each one is accepted.
module tb_aes_block_tx_ctrl;
   localparam int unsigned NB  = 16;
   localparam int unsigned DEB = 4;
   localparam int unsigned DW  = 8 * NB;
   localparam int unsigned SW  = $clog2(NB + 1);

   localparam logic [DW-1:0] PLAIN  = 128'h48656c6c6f2044722e20416465656c21;
   localparam logic [DW-1:0] CIPHER = 128'h3925841d02dc09fbdc118597196a0b32;

   typedef struct packed {
      logic [7:0] b;
      logic [7:0] idx;
   } exp_t;

   logic          clock = 1'b0;
   logic          rst;
   logic          button;
   logic          switch;
   logic [DW-1:0] plain_data;
   logic [DW-1:0] cipher_data;
   logic          cipher_valid;
   logic          busy0, done0, busy1, done1;
   logic [SW-1:0] bs0, bs1;

   aes_block_tx_ctrl_if tx0();
   aes_block_tx_ctrl_if tx1();

   aes_block_tx_ctrl #(.NUM_BYTES(NB), .DEBOUNCE_CYCLES(DEB), .MSB_FIRST(1'b1)) u_msb (
      .clock(clock), .rst(rst), .button(button), .switch(switch),
      .plain_data(plain_data), .cipher_data(cipher_data), .cipher_valid(cipher_valid),
      .tx(tx0), .busy(busy0), .done(done0), .bytes_sent(bs0));

   aes_block_tx_ctrl #(.NUM_BYTES(NB), .DEBOUNCE_CYCLES(DEB), .MSB_FIRST(1'b0)) u_lsb (
      .clock(clock), .rst(rst), .button(button), .switch(switch),
      .plain_data(plain_data), .cipher_data(cipher_data), .cipher_valid(cipher_valid),
      .tx(tx1), .busy(busy1), .done(done1), .bytes_sent(bs1));

   always #5 clock = ~clock;

   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   rmode0 = 0;   // 0: ready high, 1: toggle, 2: random
   int   rmode1 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte k of an MSB-first stream is the k-th most significant byte.
   task automatic push_block(input logic [DW-1:0] blk);
      exp_t e;
      for (int k = 0; k < int'(NB); k++) begin
         e.idx = 8'(k);
         e.b   = blk[8*(int'(NB)-1-k) +: 8];
         q0.push_back(e);
         e.b   = blk[8*k +: 8];
         q1.push_back(e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press();
      button = 1'b1;
      tick(10);
      button = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy0 || busy1) && n < 2000) begin
         tick(1);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy never dropped", name);
      end
      tick(3);
      chk({name, "_q_msb_drained"}, 32'(q0.size()), 32'd0);
      chk({name, "_q_lsb_drained"}, 32'(q1.size()), 32'd0);
      chk({name, "_bytes_sent_msb"}, 32'(bs0), 32'(NB));
      chk({name, "_bytes_sent_lsb"}, 32'(bs1), 32'(NB));
   endtask

   // Ready drivers for the two UART sinks.
   always @(posedge clock) begin
      #1;
      case (rmode0)
         1:       tx0.byte_ready = ~tx0.byte_ready;
         2:       tx0.byte_ready = 1'($urandom_range(0, 1));
         default: tx0.byte_ready = 1'b1;
      endcase
      case (rmode1)
         1:       tx1.byte_ready = ~tx1.byte_ready;
         2:       tx1.byte_ready = 1'($urandom_range(0, 1));
         default: tx1.byte_ready = 1'b1;
      endcase
   end

   // Monitor: on every accepted byte pop the scoreboard; also checks stall hold and done pulse.
   logic       stall_q[2];
   logic       fin_q[2];
   logic [7:0] held_q[2];
   logic [7:0] m_bd;
   logic       m_bv, m_br, m_dn;
   logic [SW-1:0] m_bs;
   exp_t       m_e;
   int         m_qs;

   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            stall_q[d] = 1'b0;
            fin_q[d]   = 1'b0;
         end else begin
            m_bd = (d == 0) ? tx0.byte_data  : tx1.byte_data;
            m_bv = (d == 0) ? tx0.byte_valid : tx1.byte_valid;
            m_br = (d == 0) ? tx0.byte_ready : tx1.byte_ready;
            m_dn = (d == 0) ? done0 : done1;
            m_bs = (d == 0) ? bs0 : bs1;
            m_qs = (d == 0) ? q0.size() : q1.size();
            if (stall_q[d]) begin
               chk("stall_valid_held", 32'(m_bv), 32'd1);
               chk("stall_data_held", 32'(m_bd), 32'(held_q[d]));
            end
            if (m_dn || fin_q[d]) begin
               chk("done_pulse", 32'(m_dn), 32'(fin_q[d]));
               chk("done_bytes_sent", 32'(m_bs), 32'(NB));
            end
            fin_q[d] = 1'b0;
            if (m_bv && m_br) begin
               if (m_qs == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte dut%0d: got 0x%0h with no byte expected", d, m_bd);
               end else begin
                  m_e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  chk((d == 0) ? "byte_msb" : "byte_lsb", 32'(m_bd), 32'(m_e.b));
                  chk("bytes_sent_progress", 32'(m_bs), 32'(m_e.idx));
                  fin_q[d] = (m_e.idx == 8'(NB - 1));
               end
            end
            stall_q[d] = m_bv && !m_br;
            held_q[d]  = m_bd;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbv, first, donecyc, any_busy, n;
      logic [DW-1:0] blk;
      rst          = 1'b1;
      button       = 1'b0;
      switch       = 1'b0;
      cipher_valid = 1'b0;
      plain_data   = PLAIN;
      cipher_data  = CIPHER;
      tx0.byte_ready = 1'b1;
      tx1.byte_ready = 1'b1;
      tick(3);
      chk("rst_valid_msb", 32'(tx0.byte_valid), 32'd0);
      chk("rst_busy_msb", 32'(busy0), 32'd0);
      chk("rst_done_msb", 32'(done0), 32'd0);
      chk("rst_sent_msb", 32'(bs0), 32'd0);
      chk("rst_data_lsb", 32'(tx1.byte_data), 32'd0);
      chk("rst_busy_lsb", 32'(busy1), 32'd0);
      rst = 1'b0;
      tick(2);

      // plaintext, MSB sink always ready, LSB sink toggling
      rmode0 = 0;
      rmode1 = 1;
      push_block(PLAIN);
      button = 1'b1;
      nbv = 0; first = -1; donecyc = -1;
      for (int c = 0; c < 60; c++) begin
         tick(1);
         if (c == 9) button = 1'b0;
         if (tx0.byte_valid) begin
            nbv++;
            if (first < 0) first = c;
         end
         if (done0) donecyc = c;
      end
      chk("t1_valid_cycles", 32'(nbv), 32'(NB));
      chk("t1_done_after_last", 32'(donecyc - first), 32'(NB));
      wait_idle("t1");
      tick(20);
      chk("t1_single_transfer", 32'(q0.size() + q1.size()), 32'd0);

      // ciphertext not yet valid at the trigger
      rmode1 = 2;
      switch = 1'b1;
      push_block(CIPHER);
      press();
      for (int c = 0; c < 20; c++) begin
         chk("t2_wait_busy", 32'(busy0), 32'd1);
         chk("t2_wait_no_valid", 32'(tx0.byte_valid), 32'd0);
         chk("t2_wait_sent_cleared", 32'(bs0), 32'd0);
         tick(1);
      end
      cipher_valid = 1'b1;
      #1;
      chk("t2_no_valid_same_cycle", 32'(tx0.byte_valid), 32'd0);
      tick(1);
      chk("t2_valid_next_cycle", 32'(tx0.byte_valid), 32'd1);
      chk("t2_first_byte", 32'(tx0.byte_data), 32'h39);
      wait_idle("t2");
      switch       = 1'b0;
      cipher_valid = 1'b0;

      // bouncing button never triggers
      any_busy = 0;
      for (int p = 0; p < 8; p++) begin
         button = 1'b1;
         n = int'($urandom_range(1, 3));
         for (int c = 0; c < n; c++) begin tick(1); if (busy0 || busy1) any_busy = 1; end
         button = 1'b0;
         n = int'($urandom_range(2, 5));
         for (int c = 0; c < n; c++) begin tick(1); if (busy0 || busy1) any_busy = 1; end
      end
      for (int c = 0; c < 10; c++) begin tick(1); if (busy0 || busy1) any_busy = 1; end
      chk("t3_bounce_no_trigger", 32'(any_busy), 32'd0);

      // second press and input changes during SEND are ignored
      rmode0 = 2;
      rmode1 = 2;
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      plain_data = blk;
      push_block(blk);
      press();
      chk("t4_busy_after_press", 32'(busy0), 32'd1);
      switch       = 1'b1;
      cipher_valid = 1'b1;
      plain_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      cipher_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick(2);
      press();
      wait_idle("t4");
      switch       = 1'b0;
      cipher_valid = 1'b0;
      plain_data   = PLAIN;
      cipher_data  = CIPHER;

      // reset after five accepted bytes
      rmode0 = 0;
      rmode1 = 0;
      tick(5);
      push_block(PLAIN);
      button = 1'b1;
      n = 0;
      while (q0.size() != int'(NB) - 5 && n < 100) begin
         tick(1);
         n++;
         if (n == 10) button = 1'b0;
      end
      chk("t5_five_accepted", 32'(q0.size()), 32'(NB - 5));
      chk("t5_sent_before_rst", 32'(bs0), 32'd5);
      rst    = 1'b1;
      button = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(tx0.byte_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy0), 32'd0);
      chk("t5_rst_sent", 32'(bs0), 32'd0);
      chk("t5_rst_valid_lsb", 32'(tx1.byte_valid), 32'd0);
      q0.delete();
      q1.delete();
      tick(2);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick(1);
         chk("t5_no_done_after_rst", 32'(done0 | done1), 32'd0);
      end
      push_block(PLAIN);
      press();
      wait_idle("t5");

      // random blocks, sources and ready patterns
      for (int t = 0; t < 4; t++) begin
         rmode0 = 2;
         rmode1 = 2;
         blk    = {$urandom(), $urandom(), $urandom(), $urandom()};
         switch = 1'($urandom_range(0, 1));
         cipher_valid = 1'($urandom_range(0, 1));
         if (switch) cipher_data = blk;
         else        plain_data  = blk;
         push_block(blk);
         press();
         if (switch && !cipher_valid) begin
            tick(int'($urandom_range(1, 10)));
            cipher_valid = 1'b1;
         end
         wait_idle("t6");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_block_tx_ctrl.md
Name: aes_block_tx_ctrl

Overview:
Parametrised transmit controller between the AES encryptor and the byte-wide UART transmitter.
- A debounced push-button starts a transfer.
- A switch selects the source block: plaintext or ciphertext.
- The block latches the selected NUM_BYTES-wide block and streams it byte by byte over a valid/ready handshake.
- Adds what the current top level lacks: configurable block width, byte order and debounce time; a wait for ciphertext validity; busy/done status.

Parameters:
NUM_BYTES, 16, bytes per block (>=1); data buses are 8*NUM_BYTES bits.
DEBOUNCE_CYCLES, 15000000, consecutive synchronised-high cycles before a press is accepted (>=2).
MSB_FIRST, 1, 1: send bits [8N-1:8N-8] first; 0: send bits [7:0] first.

Ports:
clock  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-high reset.
button  in  1  raw push-button, asynchronous to clock.
switch  in  1  source select at trigger time: 1 = cipher_data, 0 = plain_data.
plain_data  in  8*NUM_BYTES  plaintext block.
cipher_data  in  8*NUM_BYTES  ciphertext block from the AES core.
cipher_valid  in  1  cipher_data is stable and valid.
byte_data  out  8  current byte to the UART.
byte_valid  out  1  byte_data is valid.
byte_ready  in  1  UART accepts byte this cycle.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last byte is accepted.
bytes_sent  out  $clog2(NUM_BYTES+1)  bytes accepted in current/last transfer.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, debounce counter 0, debouncer armed, synchroniser flops 0.
- Debounce:
  - button passes through a 2-flop synchroniser (2 cycles latency).
  - Counter increments while the synced level is 1 and saturates at DEBOUNCE_CYCLES.
  - A one-cycle trigger fires when the counter reaches DEBOUNCE_CYCLES and the debouncer is armed; firing clears armed.
  - Synced level 0 clears the counter and sets armed. Exactly one trigger per press.
- FSM states: IDLE, WAIT_SRC, SEND, FIN.
  - IDLE: on trigger, if switch=0, latch plain_data into the shift register and go to SEND. If switch=1 and cipher_valid=1, latch cipher_data and go to SEND. If switch=1 and cipher_valid=0, go to WAIT_SRC.
  - WAIT_SRC: on cipher_valid=1, latch cipher_data and go to SEND. switch is not re-sampled.
  - SEND:
    - byte_valid=1; byte_data = next byte per MSB_FIRST.
    - On byte_valid&&byte_ready: bytes_sent increments and the next byte is presented in the following cycle with byte_valid held high (back-to-back allowed).
    - byte_data is stable while byte_valid&&!byte_ready.
    - Acceptance of byte NUM_BYTES goes to FIN with byte_valid=0.
  - FIN: done=1 for one cycle, then IDLE. bytes_sent holds NUM_BYTES until the next trigger clears it to 0.
- First byte_valid rises the cycle after the latch.
- Latency: a NUM_BYTES transfer with byte_ready tied high takes NUM_BYTES cycles of byte_valid, plus 1 FIN cycle.
- Triggers in WAIT_SRC, SEND and FIN are ignored and not queued.
- switch and input-bus changes after the latch do not affect the transfer.
- byte_ready while byte_valid=0 is ignored.
- rst mid-transfer: byte_valid and busy drop immediately; no done pulse; the partial block is discarded.
- NUM_BYTES=1: single byte, then FIN.

Test Plan:
- Bench settings: NUM_BYTES=16, DEBOUNCE_CYCLES=4, MSB_FIRST=1, byte_ready=1, switch=0, plain=0x48656c6c6f2044722e20416465656c21. Press button 10 cycles -> bytes 0x48,0x65,...,0x6c,0x21 on consecutive cycles; done one cycle after 0x21; bytes_sent=16; one transfer only.
- switch=1, cipher=0x3925841d02dc09fbdc118597196a0b32, cipher_valid=0 at trigger, raised 20 cycles later -> busy throughout; no byte_valid until 1 cycle after cipher_valid; first byte 0x39, last 0x32.
- MSB_FIRST=0, same plaintext, byte_ready toggling 1-0-1-0 -> order 0x21,0x6c,0x65,...,0x48; each byte_data held stable across stall cycles; no duplicate or skipped byte.
- Button bouncing (pulses of 1-3 cycles) -> no trigger. Second press during SEND -> ignored, exactly 16 bytes. Flip switch mid-transfer -> bytes unchanged.
- Assert rst after 5 accepted bytes -> byte_valid, busy, bytes_sent=0 immediately; no done. New press -> full 16-byte transfer from byte 0x48.
